// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
// Module : dmem_arbiter_pkg
// Brief  : Shared types and constants for the data-memory arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_t;

   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 4;
   localparam int CNT_W   = 2;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// Module : dmem_arbiter_if
// Brief  : Requester ports and data-memory bus seen by the arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
   parameter int ADDR_W = 14
);
   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic [31:0]       addr0;
   logic [31:0]       addr1;
   logic [31:0]       wdata0;
   logic [31:0]       wdata1;
   logic              gnt0;
   logic              gnt1;
   logic              rvalid0;
   logic              rvalid1;
   logic [31:0]       rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   // Arbiter side
   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      output gnt0, gnt1, rvalid0, rvalid1, rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   // Requesters plus memory side
   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Two-way round-robin selector holding the last-served port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_pick
   import dmem_arbiter_pkg::*;
(
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic req0,
   input  wire logic req1,
   input  wire logic take,
   output logic      pick
);

   logic last_q;
   logic last_d;

   always_comb begin
      if (req0 && req1) begin
         pick = ~last_q;
      end else if (req1) begin
         pick = PORT1;
      end else begin
         pick = PORT0;
      end
      last_d = take ? pick : last_q;
   end

   // Pointer starts at port 1 so port 0 wins the first tie
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= PORT1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module : dmem_arbiter
// Brief  : Round-robin arbiter sharing one data memory between CPU and loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 14,
   parameter int LAT    = 1
) (
   input  wire logic     clk,
   input  wire logic     rst,
   dmem_arbiter_if.slave bus
);

   // Out-of-range latencies are clamped into the supported window
   localparam int              LAT_C    = (LAT < LAT_MIN) ? LAT_MIN :
                                          (LAT > LAT_MAX) ? LAT_MAX : LAT;
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LAT_C - 1);

   arb_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              port_q, port_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;

   logic              any_req;
   logic              take;
   logic              pick;
   logic              issue;
   logic              done;

   assign any_req = bus.req0 | bus.req1;
   assign take    = (state_q == ST_IDLE) && any_req;

   rr_pick u_rr_pick (
      .clk  (clk),
      .rst  (rst),
      .req0 (bus.req0),
      .req1 (bus.req1),
      .take (take),
      .pick (pick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         port_q  <= PORT0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         port_q  <= port_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      port_d  = port_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d = ST_ISSUE;
               port_d  = pick;
               we_d    = pick ? bus.we1 : bus.we0;
               addr_d  = pick ? bus.addr1[ADDR_W+1:2] : bus.addr0[ADDR_W+1:2];
               wdata_d = pick ? bus.wdata1 : bus.wdata0;
            end
         end
         ST_ISSUE: begin
            if (we_q) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
               cnt_d   = LAT_LOAD;
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      issue = 1'b0;
      done  = 1'b0;
      case (state_q)
         ST_ISSUE: issue = 1'b1;
         ST_WAIT:  done  = (cnt_q == '0);
         default:  ;
      endcase
   end

   assign bus.gnt0      = issue & (port_q == PORT0);
   assign bus.gnt1      = issue & (port_q == PORT1);
   assign bus.rvalid0   = done  & (port_q == PORT0);
   assign bus.rvalid1   = done  & (port_q == PORT1);
   assign bus.rdata     = done ? bus.mem_rdata : '0;
   assign bus.mem_en    = issue;
   assign bus.mem_we    = issue & we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

   // Byte-lane and high address bits are not part of the word address
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.addr0[31:ADDR_W+2], bus.addr0[1:0],
                               bus.addr1[31:ADDR_W+2], bus.addr1[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module : tb_dmem_arbiter
// Brief  : Scoreboarded bench for dmem_arbiter with a LAT-stage memory model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

   localparam int ADDR_W    = 14;
   localparam int LAT       = 2;
   localparam int MEM_WORDS = 1 << ADDR_W;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   dmem_arbiter #(.ADDR_W(ADDR_W), .LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic        cur_req   [2];
   logic        cur_we    [2];
   logic [31:0] cur_addr  [2];
   logic [31:0] cur_wdata [2];

   assign bus.req0   = cur_req[0];
   assign bus.req1   = cur_req[1];
   assign bus.we0    = cur_we[0];
   assign bus.we1    = cur_we[1];
   assign bus.addr0  = cur_addr[0];
   assign bus.addr1  = cur_addr[1];
   assign bus.wdata0 = cur_wdata[0];
   assign bus.wdata1 = cur_wdata[1];

   // Memory model: read data appears LAT cycles after the issue cycle
   logic [31:0] mem_arr [MEM_WORDS];
   logic [31:0] rd_pipe [LAT];

   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_en && !bus.mem_we) rd_pipe[0] <= mem_arr[bus.mem_addr];
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.mem_rdata = rd_pipe[LAT-1];

   // Scoreboard: expectations are pushed at grant from the requester's own record
   typedef struct packed {
      logic        port;
      logic        known;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q [$];
   logic [31:0] shadow  [MEM_WORDS];
   bit          written [MEM_WORDS];
   int          grants_seen = 0;

   always @(posedge clk) begin
      #1;
      if (rst) begin
         exp_q.delete();
      end else begin
         checks++;
         if ((bus.gnt0 && bus.gnt1) || (bus.rvalid0 && bus.rvalid1)) begin
            failures++;
            $display("FAIL overlap: gnt=%b%b rvalid=%b%b, required at most one of each",
                     bus.gnt1, bus.gnt0, bus.rvalid1, bus.rvalid0);
         end
         for (int p = 0; p < 2; p++) begin
            logic              g;
            logic              rv;
            logic [ADDR_W-1:0] w;
            exp_t              e;
            g  = (p == 1) ? bus.gnt1 : bus.gnt0;
            rv = (p == 1) ? bus.rvalid1 : bus.rvalid0;
            w  = cur_addr[p][ADDR_W+1:2];
            if (rv) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL sb_unexpected_rvalid: port %0d rdata=%h, required no rvalid", p, bus.rdata);
               end else begin
                  e = exp_q.pop_front();
                  if (e.port !== p[0] || (e.known && bus.rdata !== e.data)) begin
                     failures++;
                     $display("FAIL sb_read: port %0d rdata=%h, required port %0d rdata=%h",
                              p, bus.rdata, e.port, e.data);
                  end
               end
            end
            if (g) begin
               checks++;
               grants_seen++;
               if (!cur_req[p] || bus.mem_en !== 1'b1 || bus.mem_we !== cur_we[p] ||
                   bus.mem_addr !== w || bus.mem_wdata !== cur_wdata[p]) begin
                  failures++;
                  $display("FAIL sb_issue: port %0d en=%b we=%b addr=%h wdata=%h, required req=1 en=1 we=%b addr=%h wdata=%h",
                           p, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                           cur_we[p], w, cur_wdata[p]);
               end
               if (cur_we[p]) begin
                  shadow[w]  = cur_wdata[p];
                  written[w] = 1'b1;
               end else begin
                  exp_q.push_back('{port: p[0], known: written[w], data: shadow[w]});
               end
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_en, bus.mem_we} !== 6'b0) begin
         failures++;
         $display("FAIL reset_ctrl: gnt/rvalid/en/we=%b, required 000000",
                  {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_en, bus.mem_we});
      end
      checks++;
      if (bus.mem_addr !== '0 || bus.mem_wdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_bus: mem_addr=%h mem_wdata=%h, required 0 0", bus.mem_addr, bus.mem_wdata);
      end
      checks++;
      if (bus.rdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_rdata: rdata=%h, required 0", bus.rdata);
      end
      #2;
      rst = 1'b0;
   endtask

   task automatic test_write_p0();
      cur_req[0] = 1'b1; cur_we[0] = 1'b1; cur_addr[0] = 32'h10; cur_wdata[0] = 32'hDEADBEEF;
      @(posedge clk); #1;
      checks++;
      if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
         failures++;
         $display("FAIL wr_gnt: gnt0=%b gnt1=%b, required 1 0", bus.gnt0, bus.gnt1);
      end
      checks++;
      if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1) begin
         failures++;
         $display("FAIL wr_strobe: en=%b we=%b, required 1 1", bus.mem_en, bus.mem_we);
      end
      checks++;
      if (bus.mem_addr !== 14'd4) begin
         failures++;
         $display("FAIL wr_addr: mem_addr=%h, required 0004", bus.mem_addr);
      end
      checks++;
      if (bus.mem_wdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL wr_data: mem_wdata=%h, required deadbeef", bus.mem_wdata);
      end
      #2; cur_req[0] = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.gnt0 !== 1'b0 || bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin
         failures++;
         $display("FAIL wr_one_cycle: gnt0=%b en=%b we=%b, required 0 0 0", bus.gnt0, bus.mem_en, bus.mem_we);
      end
      #2;
   endtask

   task automatic test_read_p1();
      cur_req[1] = 1'b1; cur_we[1] = 1'b1; cur_addr[1] = 32'h20; cur_wdata[1] = 32'h12345678;
      @(posedge clk); #1;
      checks++;
      if (bus.gnt1 !== 1'b1) begin
         failures++;
         $display("FAIL rd_preload_gnt: gnt1=%b, required 1", bus.gnt1);
      end
      #2; cur_req[1] = 1'b0;
      @(posedge clk); #3;
      cur_req[1] = 1'b1; cur_we[1] = 1'b0; cur_addr[1] = 32'h20;
      @(posedge clk); #1;
      checks++;
      if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0 || bus.mem_we !== 1'b0) begin
         failures++;
         $display("FAIL rd_gnt: gnt1=%b gnt0=%b we=%b, required 1 0 0", bus.gnt1, bus.gnt0, bus.mem_we);
      end
      #2; cur_req[1] = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.rvalid1 !== 1'b0 || bus.rvalid0 !== 1'b0) begin
         failures++;
         $display("FAIL rd_early: rvalid1=%b rvalid0=%b at t+1, required 0 0", bus.rvalid1, bus.rvalid0);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.rvalid1 !== 1'b1 || bus.rvalid0 !== 1'b0 || bus.rdata !== 32'h12345678) begin
         failures++;
         $display("FAIL rd_data: rvalid1=%b rvalid0=%b rdata=%h at t+2, required 1 0 12345678",
                  bus.rvalid1, bus.rvalid0, bus.rdata);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.rvalid1 !== 1'b0) begin
         failures++;
         $display("FAIL rd_pulse: rvalid1=%b at t+3, required 0", bus.rvalid1);
      end
      #2;
   endtask

   task automatic test_contention();
      int   gcyc [$];
      logic gport [$];
      rst = 1'b1;
      @(posedge clk); #3;
      rst = 1'b0;
      cur_req[0] = 1'b1; cur_we[0] = 1'b0; cur_addr[0] = 32'h10;
      cur_req[1] = 1'b1; cur_we[1] = 1'b0; cur_addr[1] = 32'h20;
      for (int c = 0; c < 40 && gport.size() < 4; c++) begin
         @(posedge clk); #1;
         if (bus.gnt0) begin gport.push_back(1'b0); gcyc.push_back(c); end
         if (bus.gnt1) begin gport.push_back(1'b1); gcyc.push_back(c); end
         #2;
         if (gport.size() >= 4) begin cur_req[0] = 1'b0; cur_req[1] = 1'b0; end
      end
      cur_req[0] = 1'b0; cur_req[1] = 1'b0;
      checks++;
      if (gport.size() != 4) begin
         failures++;
         $display("FAIL rr_count: grants=%0d, required 4", gport.size());
      end else begin
         checks++;
         if (gcyc[0] != 0) begin
            failures++;
            $display("FAIL rr_first_latency: first gnt at cycle %0d, required 0", gcyc[0]);
         end
         for (int i = 0; i < 4; i++) begin
            logic exp_p;
            exp_p = (i % 2) == 1;
            checks++;
            if (gport[i] !== exp_p) begin
               failures++;
               $display("FAIL rr_order: grant %0d to port %0d, required port %0d", i, gport[i], exp_p);
            end
         end
         for (int i = 1; i < 4; i++) begin
            checks++;
            if (gcyc[i] - gcyc[i-1] != 2 + LAT) begin
               failures++;
               $display("FAIL rr_spacing: gap %0d, required %0d", gcyc[i] - gcyc[i-1], 2 + LAT);
            end
         end
      end
      repeat (LAT + 1) @(posedge clk);
      #3;
   endtask

   task automatic test_burst_writes();
      int n = 0;
      int gc [$];
      cur_req[0] = 1'b1; cur_we[0] = 1'b1; cur_addr[0] = 32'h100; cur_wdata[0] = 32'hA5A50000;
      for (int c = 0; c < 20 && n < 4; c++) begin
         @(posedge clk); #1;
         if (bus.gnt0) begin n++; gc.push_back(c); end
         #2;
         if (bus.gnt0) begin
            if (n == 4) cur_req[0] = 1'b0;
            else begin cur_addr[0] += 32'd4; cur_wdata[0] += 32'd1; end
         end
      end
      cur_req[0] = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (bus.gnt0) n++;
         #2;
      end
      checks++;
      if (n != 4) begin
         failures++;
         $display("FAIL burst_count: gnt0 pulses=%0d, required 4", n);
      end
      for (int i = 1; i < gc.size(); i++) begin
         checks++;
         if (gc[i] - gc[i-1] != 2) begin
            failures++;
            $display("FAIL burst_spacing: gap %0d, required 2", gc[i] - gc[i-1]);
         end
      end
   endtask

   task automatic test_reset_abort();
      int rv_seen = 0;
      cur_req[0] = 1'b1; cur_we[0] = 1'b0; cur_addr[0] = 32'h10;
      @(posedge clk); #1;
      checks++;
      if (bus.gnt0 !== 1'b1) begin
         failures++;
         $display("FAIL abort_gnt: gnt0=%b, required 1", bus.gnt0);
      end
      #2; cur_req[0] = 1'b0;
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_en, bus.mem_we} !== 6'b0 ||
          bus.rdata !== 32'h0) begin
         failures++;
         $display("FAIL abort_outputs: ctrl=%b rdata=%h, required 000000 0",
                  {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_en, bus.mem_we}, bus.rdata);
      end
      @(posedge clk); #3;
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (bus.rvalid0 || bus.rvalid1) rv_seen++;
         #2;
      end
      checks++;
      if (rv_seen != 0) begin
         failures++;
         $display("FAIL abort_no_rvalid: rvalid cycles=%0d, required 0", rv_seen);
      end
      cur_req[0] = 1'b1; cur_we[0] = 1'b1; cur_addr[0] = 32'h200; cur_wdata[0] = 32'h0BADF00D;
      cur_req[1] = 1'b1; cur_we[1] = 1'b1; cur_addr[1] = 32'h204; cur_wdata[1] = 32'hCAFEF00D;
      @(posedge clk); #1;
      checks++;
      if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
         failures++;
         $display("FAIL abort_tie: gnt0=%b gnt1=%b, required 1 0", bus.gnt0, bus.gnt1);
      end
      #2; cur_req[0] = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      checks++;
      if (bus.gnt1 !== 1'b1) begin
         failures++;
         $display("FAIL abort_tie_next: gnt1=%b, required 1", bus.gnt1);
      end
      #2; cur_req[1] = 1'b0;
      @(posedge clk); #3;
   endtask

   task automatic test_random();
      int start_grants;
      start_grants = grants_seen;
      for (int c = 0; c < 10000; c++) begin
         @(posedge clk); #3;
         for (int p = 0; p < 2; p++) begin
            logic g;
            int   word;
            g = (p == 1) ? bus.gnt1 : bus.gnt0;
            if (!cur_req[p] || g) begin
               word         = $urandom_range(0, 31);
               cur_req[p]   = ($urandom_range(0, 99) < 60);
               cur_we[p]    = 1'($urandom_range(0, 1));
               cur_addr[p]  = ($urandom() & 32'hFFFF_0003) | (32'(word) << 2);
               cur_wdata[p] = $urandom();
            end
         end
      end
      cur_req[0] = 1'b0; cur_req[1] = 1'b0;
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL rand_drain: pending reads=%0d, required 0", exp_q.size());
      end
      checks++;
      if (grants_seen - start_grants < 1000) begin
         failures++;
         $display("FAIL rand_activity: grants=%0d, required at least 1000", grants_seen - start_grants);
      end
   endtask

   initial begin
      for (int p = 0; p < 2; p++) begin
         cur_req[p] = 1'b0; cur_we[p] = 1'b0; cur_addr[p] = '0; cur_wdata[p] = '0;
      end
      #2;
      test_reset();
      test_write_p0();
      test_read_p1();
      test_contention();
      test_burst_writes();
      test_reset_abort();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, word-address width driven to the data memory.
REQ-002 Parameter LAT, default 1, data-memory read latency in cycles (legal range 1..4).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0/req1  input  1  access request from the CPU (port 0) and the debug/program loader (port 1).
REQ-006 we0/we1  input  1  1 = write, 0 = read, per port.
REQ-007 addr0/addr1  input  32  byte address per port; bits [ADDR_W+1:2] are used.
REQ-008 wdata0/wdata1  input  32  write data per port.
REQ-009 gnt0/gnt1  output  1  one-cycle pulse: the command was issued to memory this cycle.
REQ-010 rvalid0/rvalid1  output  1  one-cycle pulse: read data valid on rdata this cycle.
REQ-011 rdata  output  32  read data shared by both ports; meaningful only while an rvalid is high.
REQ-012 mem_en, mem_we  output  1  memory enable and write strobe.
REQ-013 mem_addr  output  ADDR_W  memory word address.
REQ-014 mem_wdata  output  32  memory write data; mem_rdata  input  32  memory read data.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT.
REQ-016 IDLE: if req0 or req1 is high, the FSM SHALL select a winner, register its we/addr/wdata, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: with both requests high, the port not served last wins; with one request high, that port wins; the last-served pointer resets to port 1, so port 0 wins the first tie.
REQ-018 ISSUE lasts exactly one cycle: mem_en=1, mem_we=registered we, and mem_addr/mem_wdata=registered values; the winner's gnt is high for that cycle only.
REQ-019 From ISSUE, a write SHALL go to IDLE and a read SHALL go to WAIT with a latency counter loaded with LAT-1.
REQ-020 WAIT: the counter decrements each cycle; at 0, the winner's rvalid=1 and rdata=mem_rdata (combinational pass-through) for that cycle; the FSM then goes to IDLE.
REQ-021 Latency from the IDLE cycle that samples req to gnt SHALL be 1 cycle; from gnt to rvalid SHALL be LAT cycles.
REQ-022 Requests SHALL be ignored in ISSUE and WAIT; the requester holds req/we/addr/wdata stable until gnt and may keep req high for back-to-back accesses.
REQ-023 Back-to-back throughput SHALL be one write per 2 cycles and one read per 2+LAT cycles; under continuous contention, the ports SHALL alternate strictly.
REQ-024 Outside ISSUE, mem_en=0 and mem_we=0; the gnt/rvalid outputs of both ports SHALL never be high in the same cycle.
REQ-025 A request that drops before gnt SHALL be lost without side effects only if it drops while the FSM is not in IDLE.

Reset
REQ-026 With rst high, the FSM SHALL be IDLE, all gnt/rvalid/mem_en/mem_we=0, mem_addr/mem_wdata/rdata=0, the counter=0, and the last-served pointer=port 1.
REQ-027 A reset asserted during ISSUE or WAIT SHALL abort the access immediately; no rvalid is issued afterwards.

Structure
REQ-028 FSM state encodings and the LAT bounds SHALL be placed in the shared cpu package.
REQ-029 The design SHALL contain one natural sub-module: rr_pick (2-way round-robin selector with the last-served pointer).
REQ-030 dmem_arbiter SHALL sit between MemOrIO and the data-memory instance.

Verification
REQ-031 Port 0 only, write addr 0x10 data 0xDEADBEEF -> next cycle: gnt0=1, mem_we=1, mem_addr=4, mem_wdata=0xDEADBEEF.
REQ-032 Port 1 read addr 0x20, LAT=2, memory returns 0x12345678 -> gnt1 at cycle t, rvalid1=1 with rdata=0x12345678 at t+2, rvalid0 stays 0.
REQ-033 req0 and req1 rise in the same cycle after reset, both reads -> port 0 is served first, then port 1; under sustained contention, the grant sequence is 0,1,0,1.
REQ-034 req0 held high for 4 writes while req1 idle -> gnt0 pulses every 2 cycles, 4 pulses total.
REQ-035 rst asserted in WAIT of a port-0 read -> outputs are 0 in the same cycle; no rvalid0 after release; the next tie is won by port 0.
REQ-036 Random 10k-cycle traffic against a memory model -> every read returns the last written value for its address, and no gnt/rvalid overlap occurs.
